bs_ctrl: RTL and testbench

Sequencer in front of `bs_top`: issues the start pulse and waits out its init time, paces the LZ77 symbol stream into it, and merges the Adler-32 trailer with the last symbol. It then waits for the bitstream packer to finish feeding the CRC-32 engine, hands back the final CRC, and reports frame completion. It replaces the fixed-delay and edge-wait sequencing currently done by hand around `bs_top`.

---
 rtl/bs_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_bs_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bs_ctrl.sv
// bs_ctrl -- frame sequencer in front of bs_top.
//
// Issues the bs_top start pulse and waits out its init time. Then it paces the
// LZ77 symbol stream into bs_top, holding back the last symbol until the final
// Adler-32 is known so that both leave together. Finally it waits for the
// packer to finish feeding the CRC-32 engine, returns the final CRC and
// reports frame completion.
//
// Optional build macro:
//   BS_CTRL_TIMEOUT_EN  16-bit watchdog on the CRCW/FLUSH waits. On expiry it
//                       sets err_o (sticky) and forces IDLE without done_o.
//                       When the macro is undefined, err_o is tied low.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start_i             frame start pulse (ignored unless idle)
//   sym_val_i/sym_rdy_o symbol handshake; payload sym_flg_lit_i, sym_lit_i,
//                       sym_len_i, sym_dis_i, last flag sym_lst_i
//   adler_val_i/_dat_i  final Adler-32 pulse
//   crc_val_i/_dat_i    final CRC-32 pulse from the CRC engine
//   bs_start_o          start pulse to bs_top
//   bs_val_o, bs_*      symbol port to bs_top (payload held between pulses)
//   bs_adler32_done_o   Adler trailer strobe, with bs_adler32_dat_o
//   bs_crc32_lst_i      bs_top last-CRC-feed flag (falling edge = feed done)
//   bs_crc32_val_o/_done_o/_dat_o  final CRC handed back to bs_top
//   bs_done_i           bs_top finished
//   busy_o, done_o (pulse), err_o (sticky)

module bs_ctrl #(
  parameter int LIT_DAT_WD = 8,
  parameter int LEN_DAT_WD = 7,
  parameter int DIS_DAT_WD = 7,
  parameter int DATA_WD    = 32,
  parameter int INIT_CYC   = 10,
  parameter int SYM_GAP    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  sym_val_i,
  output logic                  sym_rdy_o,
  input  logic                  sym_flg_lit_i,
  input  logic [LIT_DAT_WD-1:0] sym_lit_i,
  input  logic [LEN_DAT_WD-1:0] sym_len_i,
  input  logic [DIS_DAT_WD-1:0] sym_dis_i,
  input  logic                  sym_lst_i,
  input  logic                  adler_val_i,
  input  logic [DATA_WD-1:0]    adler_dat_i,
  input  logic                  crc_val_i,
  input  logic [DATA_WD-1:0]    crc_dat_i,
  output logic                  bs_start_o,
  output logic                  bs_val_o,
  output logic                  bs_flg_lit_o,
  output logic [LIT_DAT_WD-1:0] bs_lit_dat_o,
  output logic [LEN_DAT_WD-1:0] bs_len_dat_o,
  output logic [DIS_DAT_WD-1:0] bs_dis_dat_o,
  output logic                  bs_lst_o,
  output logic                  bs_adler32_done_o,
  output logic [DATA_WD-1:0]    bs_adler32_dat_o,
  input  logic                  bs_crc32_lst_i,
  output logic                  bs_crc32_val_o,
  output logic                  bs_crc32_done_o,
  output logic [DATA_WD-1:0]    bs_crc32_dat_o,
  input  logic                  bs_done_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [7:0] INIT_LST = 8'(INIT_CYC - 1);
  localparam logic [7:0] GAP_LD   = 8'(SYM_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_DATA, S_ADLER, S_CRCW, S_CRC, S_FLUSH
  } state_t;

  state_t state, state_nxt;

  logic [7:0]            init_cnt;
  logic [7:0]            gap_cnt;
  logic                  adl_ok;
  logic [DATA_WD-1:0]    adl_dat;
  logic                  crc_ok;
  logic [DATA_WD-1:0]    crc_dat;
  logic                  lst_q;
  logic                  fed;

  logic                  start_p1;
  logic                  done_p1;
  logic                  vld_p1;
  logic                  flg_p1;
  logic [LIT_DAT_WD-1:0] lit_p1;
  logic [LEN_DAT_WD-1:0] len_p1;
  logic [DIS_DAT_WD-1:0] dis_p1;

  logic sym_rdy;
  logic sym_acc;
  logic adl_fire;
  logic crc_fall;
  logic fed_now;
  logic crc_ok_now;
  logic frame_go;
  logic wd_exp;

  assign frame_go = (state == S_IDLE) && start_i;
  assign sym_rdy  = (state == S_DATA) && (gap_cnt == 8'd0);
  assign sym_acc  = sym_val_i && sym_rdy;
  // Trailer leaves the cycle after the Adler latch fills (or right after the
  // last-symbol accept when it is already full).
  assign adl_fire = (state == S_ADLER) && adl_ok && (gap_cnt == 8'd0);
  assign crc_fall = lst_q && !bs_crc32_lst_i;
  // Include this cycle's events so the CRC pulse lands one cycle after the
  // later of the two, rather than two.
  assign fed_now    = fed || crc_fall;
  assign crc_ok_now = crc_ok || crc_val_i;

`ifdef BS_CTRL_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        err_q;

  assign wd_exp = ((state == S_CRCW) || (state == S_FLUSH)) && (wd_cnt == 16'hFFFF);
  assign err_o  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      if (state_nxt != state)
        wd_cnt <= 16'd0;
      else if ((state == S_CRCW) || (state == S_FLUSH))
        wd_cnt <= wd_cnt + 16'd1;
      else
        wd_cnt <= 16'd0;
      if (wd_exp)
        err_q <= 1'b1;
    end
  end
`else
  assign wd_exp = 1'b0;
  assign err_o  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_i) state_nxt = S_INIT;
      S_INIT:  if (init_cnt == INIT_LST) state_nxt = S_DATA;
      S_DATA:  if (sym_acc && sym_lst_i) state_nxt = S_ADLER;
      S_ADLER: if (adl_fire) state_nxt = S_CRCW;
      S_CRCW:  if (fed_now && crc_ok_now) state_nxt = S_CRC;
      S_CRC:   state_nxt = S_FLUSH;
      S_FLUSH: if (bs_done_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (wd_exp)
      state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      init_cnt <= 8'd0;
      gap_cnt  <= 8'd0;
      adl_ok   <= 1'b0;
      adl_dat  <= '0;
      crc_ok   <= 1'b0;
      crc_dat  <= '0;
      lst_q    <= 1'b0;
      fed      <= 1'b0;
    end else begin
      state <= state_nxt;
      lst_q <= bs_crc32_lst_i;

      if (state == S_INIT)
        init_cnt <= init_cnt + 8'd1;
      else
        init_cnt <= 8'd0;

      if (state == S_IDLE)
        gap_cnt <= 8'd0;
      else if (sym_acc && !sym_lst_i)
        gap_cnt <= GAP_LD;
      else if (gap_cnt != 8'd0)
        gap_cnt <= gap_cnt - 8'd1;

      if (frame_go) begin
        adl_ok  <= 1'b0;
        adl_dat <= '0;
      end else if ((state != S_IDLE) && adler_val_i) begin
        adl_ok  <= 1'b1;
        adl_dat <= adler_dat_i;
      end

      if (frame_go) begin
        crc_ok  <= 1'b0;
        crc_dat <= '0;
      end else if ((state != S_IDLE) && crc_val_i) begin
        crc_ok  <= 1'b1;
        crc_dat <= crc_dat_i;
      end

      if (frame_go)
        fed <= 1'b0;
      else if ((state == S_CRCW) && crc_fall)
        fed <= 1'b1;
    end
  end

  // ---- stage p1: registered start/done strobes and symbol port ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_p1 <= 1'b0;
      done_p1  <= 1'b0;
      vld_p1   <= 1'b0;
      flg_p1   <= 1'b0;
      lit_p1   <= '0;
      len_p1   <= '0;
      dis_p1   <= '0;
    end else begin
      start_p1 <= frame_go;
      done_p1  <= (state == S_FLUSH) && bs_done_i;
      // The last symbol is captured but held back for the Adler trailer.
      vld_p1   <= sym_acc && !sym_lst_i;
      if (sym_acc) begin
        flg_p1 <= sym_flg_lit_i;
        lit_p1 <= sym_lit_i;
        len_p1 <= sym_len_i;
        dis_p1 <= sym_dis_i;
      end
    end
  end

  assign sym_rdy_o         = sym_rdy;
  assign bs_start_o        = start_p1;
  assign bs_val_o          = vld_p1 || adl_fire;
  assign bs_flg_lit_o      = flg_p1;
  assign bs_lit_dat_o      = lit_p1;
  assign bs_len_dat_o      = len_p1;
  assign bs_dis_dat_o      = dis_p1;
  assign bs_lst_o          = adl_fire;
  assign bs_adler32_done_o = adl_fire;
  assign bs_adler32_dat_o  = adl_dat;
  assign bs_crc32_val_o    = (state == S_CRC);
  assign bs_crc32_done_o   = (state == S_CRC);
  assign bs_crc32_dat_o    = crc_dat;
  assign busy_o            = (state != S_IDLE);
  assign done_o            = done_p1;

endmodule

// File: tb/tb_bs_ctrl.sv
module tb_bs_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, start_g;
  logic        sym_val_i, sym_val_g;
  logic        sym_flg_lit_i;
  logic [7:0]  sym_lit_i;
  logic [6:0]  sym_len_i, sym_dis_i;
  logic        sym_lst_i;
  logic        adler_val_i, crc_val_i;
  logic [31:0] adler_dat_i, crc_dat_i;
  logic        bs_crc32_lst_i, bs_done_i;

  logic        sym_rdy, bs_start, bs_val, bs_flg, bs_lst, adl_done;
  logic [7:0]  bs_lit;
  logic [6:0]  bs_len, bs_dis;
  logic [31:0] adl_dat, crc_dat;
  logic        crc_val_o, crc_done_o, busy, done, err;

  logic        g_rdy, g_start, g_val, g_flg, g_lst, g_adl_done;
  logic [7:0]  g_lit;
  logic [6:0]  g_len, g_dis;
  logic [31:0] g_adl_dat, g_crc_dat;
  logic        g_crc_val, g_crc_done, g_busy, g_done, g_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bs_ctrl #(.INIT_CYC(10), .SYM_GAP(1)) u_dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .sym_val_i(sym_val_i), .sym_rdy_o(sym_rdy),
    .sym_flg_lit_i(sym_flg_lit_i), .sym_lit_i(sym_lit_i),
    .sym_len_i(sym_len_i), .sym_dis_i(sym_dis_i), .sym_lst_i(sym_lst_i),
    .adler_val_i(adler_val_i), .adler_dat_i(adler_dat_i),
    .crc_val_i(crc_val_i), .crc_dat_i(crc_dat_i),
    .bs_start_o(bs_start), .bs_val_o(bs_val), .bs_flg_lit_o(bs_flg),
    .bs_lit_dat_o(bs_lit), .bs_len_dat_o(bs_len), .bs_dis_dat_o(bs_dis),
    .bs_lst_o(bs_lst), .bs_adler32_done_o(adl_done), .bs_adler32_dat_o(adl_dat),
    .bs_crc32_lst_i(bs_crc32_lst_i), .bs_crc32_val_o(crc_val_o),
    .bs_crc32_done_o(crc_done_o), .bs_crc32_dat_o(crc_dat),
    .bs_done_i(bs_done_i), .busy_o(busy), .done_o(done), .err_o(err)
  );

  bs_ctrl #(.INIT_CYC(10), .SYM_GAP(4)) u_gap (
    .clk(clk), .rst(rst), .start_i(start_g),
    .sym_val_i(sym_val_g), .sym_rdy_o(g_rdy),
    .sym_flg_lit_i(sym_flg_lit_i), .sym_lit_i(sym_lit_i),
    .sym_len_i(sym_len_i), .sym_dis_i(sym_dis_i), .sym_lst_i(sym_lst_i),
    .adler_val_i(adler_val_i), .adler_dat_i(adler_dat_i),
    .crc_val_i(crc_val_i), .crc_dat_i(crc_dat_i),
    .bs_start_o(g_start), .bs_val_o(g_val), .bs_flg_lit_o(g_flg),
    .bs_lit_dat_o(g_lit), .bs_len_dat_o(g_len), .bs_dis_dat_o(g_dis),
    .bs_lst_o(g_lst), .bs_adler32_done_o(g_adl_done), .bs_adler32_dat_o(g_adl_dat),
    .bs_crc32_lst_i(bs_crc32_lst_i), .bs_crc32_val_o(g_crc_val),
    .bs_crc32_done_o(g_crc_done), .bs_crc32_dat_o(g_crc_dat),
    .bs_done_i(bs_done_i), .busy_o(g_busy), .done_o(g_done), .err_o(g_err)
  );

  typedef struct {
    logic       val;
    logic       flg;
    logic [7:0] lit;
    logic [6:0] len;
    logic [6:0] dis;
    logic       e_val;
    logic       e_flg;
    logic [7:0] e_lit;
    logic [6:0] e_len;
    logic [6:0] e_dis;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a frame on the main instance and measure start-to-ready latency.
  task automatic start_frame();
    int k;
    start_i = 1'b1;
    tick();
    chk("bs_start_pulse", 32'(bs_start), 32'd1);
    start_i = 1'b0;
    k = 0;
    do begin
      tick();
      k++;
      if (k == 1) chk("bs_start_one_cycle", 32'(bs_start), 32'd0);
    end while (!sym_rdy && k < 50);
    chk("init_latency", 32'(k), 32'd10);
  endtask

  initial begin
    int k;
    int pulses;
    rst = 1'b1;
    start_i = 1'b0; start_g = 1'b0;
    sym_val_i = 1'b0; sym_val_g = 1'b0;
    sym_flg_lit_i = 1'b0; sym_lit_i = 8'h00; sym_len_i = 7'h00; sym_dis_i = 7'h00;
    sym_lst_i = 1'b0;
    adler_val_i = 1'b0; adler_dat_i = 32'h0;
    crc_val_i = 1'b0; crc_dat_i = 32'h0;
    bs_crc32_lst_i = 1'b0; bs_done_i = 1'b0;

    vecs[0] = '{1'b1, 1'b1, 8'h41, 7'h00, 7'h00, 1'b1, 1'b1, 8'h41, 7'h00, 7'h00};
    vecs[1] = '{1'b1, 1'b1, 8'h42, 7'h00, 7'h00, 1'b1, 1'b1, 8'h42, 7'h00, 7'h00};
    vecs[2] = '{1'b1, 1'b1, 8'h43, 7'h00, 7'h00, 1'b1, 1'b1, 8'h43, 7'h00, 7'h00};
    vecs[3] = '{1'b1, 1'b1, 8'h44, 7'h00, 7'h00, 1'b1, 1'b1, 8'h44, 7'h00, 7'h00};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 7'h09, 7'h09, 1'b0, 1'b1, 8'h44, 7'h00, 7'h00};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 7'h0C, 7'h22, 1'b1, 1'b0, 8'h00, 7'h0C, 7'h22};
    vecs[6] = '{1'b1, 1'b0, 8'h00, 7'h7F, 7'h7F, 1'b1, 1'b0, 8'h00, 7'h7F, 7'h7F};

    // Reset state, clock running
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sym_rdy", 32'(sym_rdy), 32'd0);
    chk("rst_bs_start", 32'(bs_start), 32'd0);
    chk("rst_bs_val", 32'(bs_val), 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_crc_adl", {29'd0, crc_val_o, crc_done_o, adl_done}, 32'd0);
    chk("rst_payload", {bs_lit, bs_len, bs_dis, bs_flg, bs_lst}, 32'd0);
    chk("rst_dat", adl_dat | crc_dat, 32'd0);
    rst = 1'b0;
    tick();

    // Frame 1: table-driven symbol stream, SYM_GAP = 1
    start_frame();
    for (int i = 0; i < NV; i++) begin
      sym_val_i = vecs[i].val; sym_flg_lit_i = vecs[i].flg;
      sym_lit_i = vecs[i].lit; sym_len_i = vecs[i].len; sym_dis_i = vecs[i].dis;
      tick();
      chk($sformatf("vec%0d_val", i), 32'(bs_val), 32'(vecs[i].e_val));
      chk($sformatf("vec%0d_payload", i), {15'd0, bs_flg, bs_lit, bs_len, bs_dis},
          {15'd0, vecs[i].e_flg, vecs[i].e_lit, vecs[i].e_len, vecs[i].e_dis});
      chk($sformatf("vec%0d_lst", i), 32'(bs_lst), 32'd0);
    end

    // Last symbol held back; Adler arrives 7 cycles after the accept
    sym_val_i = 1'b1; sym_lst_i = 1'b1; sym_flg_lit_i = 1'b0;
    sym_lit_i = 8'h00; sym_len_i = 7'd5; sym_dis_i = 7'd3;
    tick();
    chk("last_no_pulse", 32'(bs_val), 32'd0);
    chk("last_rdy_drop", 32'(sym_rdy), 32'd0);
    sym_val_i = 1'b0; sym_lst_i = 1'b0;
    pulses = 0;
    repeat (6) begin
      tick();
      if (bs_val) pulses++;
    end
    chk("adler_wait_quiet", 32'(pulses), 32'd0);
    adler_val_i = 1'b1; adler_dat_i = 32'h11E60398;
    tick();
    adler_val_i = 1'b0; adler_dat_i = 32'h0;
    chk("adler_trailer", {29'd0, bs_val, bs_lst, adl_done}, 32'd7);
    chk("adler_dat", adl_dat, 32'h11E60398);
    chk("adler_last_payload", {18'd0, bs_len, bs_dis}, {18'd0, 7'd5, 7'd3});
    tick();
    chk("adler_single_cycle", {29'd0, bs_val, bs_lst, adl_done}, 32'd0);

    // CRC latched before the lst fall; stray start/done ignored in CRCW
    bs_crc32_lst_i = 1'b1;
    tick();
    crc_val_i = 1'b1; crc_dat_i = 32'hCBF43926; start_i = 1'b1; bs_done_i = 1'b1;
    tick();
    crc_val_i = 1'b0; crc_dat_i = 32'h0; start_i = 1'b0; bs_done_i = 1'b0;
    chk("crcw_ignore_start_done", {29'd0, bs_start, done, crc_val_o}, 32'd0);
    tick();
    chk("crc_wait_fall", 32'(crc_val_o), 32'd0);
    bs_crc32_lst_i = 1'b0;
    tick();
    chk("crc_after_fall", {30'd0, crc_val_o, crc_done_o}, 32'd3);
    chk("crc_dat1", crc_dat, 32'hCBF43926);
    tick();
    chk("crc_single_cycle", 32'(crc_val_o), 32'd0);
    chk("flush_busy", 32'(busy), 32'd1);
    bs_done_i = 1'b1;
    tick();
    bs_done_i = 1'b0;
    chk("done_pulse", {30'd0, done, busy}, 32'd2);
    tick();
    chk("done_single_cycle", 32'(done), 32'd0);

    // Frame 2: Adler with the last accept; CRC arrives after the fall
    start_frame();
    sym_val_i = 1'b1; sym_lst_i = 1'b1; sym_flg_lit_i = 1'b1; sym_lit_i = 8'h5A;
    adler_val_i = 1'b1; adler_dat_i = 32'hDEADBEEF;
    tick();
    sym_val_i = 1'b0; sym_lst_i = 1'b0; adler_val_i = 1'b0;
    chk("adler_same_cycle", {29'd0, bs_val, bs_lst, adl_done}, 32'd7);
    chk("adler_dat2", adl_dat, 32'hDEADBEEF);
    chk("adler2_lit", 32'(bs_lit), 32'h5A);
    tick();
    chk("adler2_single", 32'(bs_val), 32'd0);
    bs_crc32_lst_i = 1'b1;
    tick();
    bs_crc32_lst_i = 1'b0;
    tick();
    chk("crc2_wait_val_a", 32'(crc_val_o), 32'd0);
    tick();
    chk("crc2_wait_val_b", 32'(crc_val_o), 32'd0);
    crc_val_i = 1'b1; crc_dat_i = 32'h12345678;
    tick();
    crc_val_i = 1'b0;
    chk("crc2_after_val", {30'd0, crc_val_o, crc_done_o}, 32'd3);
    chk("crc_dat2", crc_dat, 32'h12345678);
    tick();
    bs_done_i = 1'b1;
    tick();
    bs_done_i = 1'b0;
    chk("done2_pulse", {30'd0, done, busy}, 32'd2);

    // Frame 3: reset in the middle of DATA
    start_frame();
    sym_val_i = 1'b1; sym_flg_lit_i = 1'b1; sym_lit_i = 8'h61;
    tick();
    sym_lit_i = 8'h62;
    tick();
    chk("pre_rst_val", 32'(bs_val), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_immediate", {29'd0, busy, sym_rdy, bs_val}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    pulses = 0;
    repeat (4) begin
      tick();
      if (bs_val || done || busy) pulses++;
    end
    sym_val_i = 1'b0;
    chk("rst_mid_quiet", 32'(pulses), 32'd0);
    chk("err_clear", 32'(err), 32'd0);

    // SYM_GAP = 4 instance, sym_val held high
    start_g = 1'b1;
    tick();
    start_g = 1'b0;
    k = 0;
    while (!g_rdy && k < 50) begin
      tick();
      k++;
    end
    chk("gap_init_latency", 32'(k), 32'd10);
    sym_val_g = 1'b1; sym_lst_i = 1'b0;
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("gap_rdy_c%0d", c), 32'(g_rdy), 32'((c % 4) == 0));
      chk($sformatf("gap_val_c%0d", c), 32'(g_val), 32'((c % 4) == 1));
      tick();
    end
    sym_val_g = 1'b0;

`ifdef BS_CTRL_TIMEOUT_EN
    // Watchdog: bs_done_i never arrives in FLUSH
    start_frame();
    sym_val_i = 1'b1; sym_lst_i = 1'b1; adler_val_i = 1'b1; adler_dat_i = 32'h1;
    tick();
    sym_val_i = 1'b0; sym_lst_i = 1'b0; adler_val_i = 1'b0;
    tick();
    bs_crc32_lst_i = 1'b1; crc_val_i = 1'b1; crc_dat_i = 32'h2;
    tick();
    bs_crc32_lst_i = 1'b0; crc_val_i = 1'b0;
    tick();
    chk("wd_crc_pulse", 32'(crc_val_o), 32'd1);
    k = 0;
    pulses = 0;
    do begin
      tick();
      k++;
      if (done) pulses++;
    end while (busy && k < 70000);
    chk("wd_cycles", 32'(k), 32'd65537);
    chk("wd_err", {30'd0, err, busy}, 32'd2);
    chk("wd_no_done", 32'(pulses), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish, limit 5ms");
    $fatal(1, "timeout");
  end

endmodule
